// File: rtl/otter_ecc_pkg.sv
// Shared definitions for the OTTER memory ECC write path.
//   - state_e   : write-path FSM states
//   - PAR_W     : number of Hamming check bits stored per 32-bit word
//   - DATA_POS  : codeword position (1..38) of each data bit 0..31
// Check bits sit at the power-of-two positions 1,2,4,8,16,32. Data bits fill
// the remaining positions in ascending order.
package otter_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int BYTES  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WRITE
  } state_e;

  // Index i holds the codeword position of data bit i.
  localparam logic [PAR_W-1:0] DATA_POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,
    6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
    6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30, 6'd31,
    6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

endpackage

// File: rtl/otter_ecc_par_gen.sv
// Combinational Hamming check-bit generator.
//   data_i : 32-bit data word
//   par_o  : 6 check bits; par_o[k] is the XOR of every data bit whose
//            codeword position has bit k set (par_o[0] guards position 1).
module otter_ecc_par_gen
  import otter_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [PAR_W-1:0]  par_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    par_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < PAR_W; k++) begin
        if (DATA_POS[i][k]) par_o[k] = par_o[k] ^ data_i[i];
      end
    end
  end

endmodule

// File: rtl/otter_mem_ecc_encoder.sv
// Write-side ECC encoder for the OTTER protected data array.
// Full-word writes are encoded and written directly; partial writes perform a
// read-modify-write: the corrected word is read back, the enabled bytes are
// merged in, and the merged word is re-encoded before writing.
// Ports:
//   MEM_CLK, MEM_RST_N     : clock, asynchronous active-low reset
//   WR_VALID/WR_READY      : write request handshake
//   WR_ADDR/WR_DATA/WR_BE  : request word address, data, byte enables
//   MEM_RDEN               : one-cycle read strobe (RMW)
//   MEM_RVALID/MEM_RDATA   : corrected read word from the checker path
//   MEM_WE                 : one-cycle write strobe
//   MEM_ADDR               : address for read or write
//   MEM_WDATA/MEM_WPAR     : data word and its check bits to store
module otter_mem_ecc_encoder
  import otter_ecc_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              MEM_CLK,
  input  logic              MEM_RST_N,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic [BYTES-1:0]  WR_BE,
  output logic              MEM_RDEN,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [PAR_W-1:0]  MEM_WPAR
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [BYTES-1:0]    be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [PAR_W-1:0]    par_q;

  logic                accept;
  logic                rd_done;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   par_src;
  logic [PAR_W-1:0]    par_out;

  assign accept  = (state_q == IDLE) && WR_VALID;
  assign rd_done = (state_q == RD_WAIT) && MEM_RVALID;

  // Enabled bytes come from the captured request, the rest from the array.
  always_comb begin
    merged = '0;
    for (int j = 0; j < BYTES; j++) begin
      merged[8*j +: 8] = be_q[j] ? data_q[8*j +: 8] : MEM_RDATA[8*j +: 8];
    end
  end

  // One generator serves both paths: the merged word is only needed while
  // waiting for read data, otherwise the incoming request is encoded.
  assign par_src = (state_q == RD_WAIT) ? merged : WR_DATA;

  otter_ecc_par_gen u_par_gen (
    .data_i (par_src),
    .par_o  (par_out)
  );

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    WR_READY = 1'b0;
    MEM_RDEN = 1'b0;
    MEM_WE   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated so the request port looks busy for the whole reset interval.
        WR_READY = MEM_RST_N;
        if (WR_VALID) begin
          if (WR_BE == '1)      state_d = WRITE;
          else if (WR_BE != '0) state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        MEM_RDEN = 1'b1;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (MEM_RVALID) state_d = WRITE;
      end
      WRITE: begin
        MEM_WE  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      // NOTE: the datapath registers are reset too, so the array-facing
      // outputs read zero during reset rather than stale values.
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      par_q   <= '0;
    end else begin
      if (accept) begin
        addr_q <= WR_ADDR;
        data_q <= WR_DATA;
        be_q   <= WR_BE;
        if (WR_BE == '1) begin
          wdata_q <= WR_DATA;
          par_q   <= par_out;
        end
      end
      if (rd_done) begin
        wdata_q <= merged;
        par_q   <= par_out;
      end
    end
  end

  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_WPAR  = par_q;

endmodule

// File: tb/tb_otter_mem_ecc_encoder.sv
// Directed bench for otter_mem_ecc_encoder, plus an encode/flip/correct
// loopback through a behavioural Hamming checker.
module tb_otter_mem_ecc_encoder;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              mem_rden;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [5:0]        mem_wpar;

  int n_checks = 0;
  int n_errors = 0;

  otter_mem_ecc_encoder #(.ADDR_W(ADDR_W)) dut (
    .MEM_CLK    (clk),
    .MEM_RST_N  (rst_n),
    .WR_VALID   (wr_valid),
    .WR_READY   (wr_ready),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .WR_BE      (wr_be),
    .MEM_RDEN   (mem_rden),
    .MEM_RVALID (mem_rvalid),
    .MEM_RDATA  (mem_rdata),
    .MEM_WE     (mem_we),
    .MEM_ADDR   (mem_addr),
    .MEM_WDATA  (mem_wdata),
    .MEM_WPAR   (mem_wpar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the falling edge, where outputs are sampled
  // and the next inputs are driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check bits as the XOR of the positions of all set data bits.
  function automatic logic [5:0] calc_par(input logic [31:0] d);
    logic [5:0] p;
    int di;
    p  = '0;
    di = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[di]) p = p ^ pos[5:0];
        di++;
      end
    end
    return p;
  endfunction

  // Read-side checker: rebuild the codeword, compute the syndrome, correct a
  // single flipped position, and extract the data bits.
  function automatic logic [31:0] decode(input logic [31:0] d, input logic [5:0] p);
    logic [38:0] cw;
    logic [5:0]  syn;
    logic [31:0] out;
    int di;
    int pk;
    cw  = '0;
    syn = '0;
    out = '0;
    di  = 0;
    pk  = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        cw[pos] = p[pk];
        pk++;
      end else begin
        cw[pos] = d[di];
        di++;
      end
    end
    for (int pos = 1; pos <= 38; pos++) begin
      if (cw[pos]) syn = syn ^ pos[5:0];
    end
    if (syn != 0 && syn <= 38) cw[syn] = ~cw[syn];
    di = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        out[di] = cw[pos];
        di++;
      end
    end
    return out;
  endfunction

  task automatic full_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [5:0] exp_par, input string tag);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = 4'hF;
    step();
    wr_valid = 1'b0;
    check({tag, "_we"},    mem_we,    1'b1);
    check({tag, "_rden"},  mem_rden,  1'b0);
    check({tag, "_ready"}, wr_ready,  1'b0);
    check({tag, "_addr"},  mem_addr,  a);
    check({tag, "_wdata"}, mem_wdata, d);
    check({tag, "_wpar"},  mem_wpar,  exp_par);
    step();
    check({tag, "_we_off"},   mem_we,   1'b0);
    check({tag, "_ready_on"}, wr_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [5:0]  p;
    logic [31:0] sd;
    logic [5:0]  sp;
    int          idx;

    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_be      = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", wr_ready,  1'b0);
    check("rst_we",    mem_we,    1'b0);
    check("rst_rden",  mem_rden,  1'b0);
    check("rst_addr",  mem_addr,  '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_wpar",  mem_wpar,  '0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", wr_ready, 1'b1);
    @(negedge clk);

    // Full writes with hand-computed check bits
    full_write(14'h0001, 32'h0000_0000, 6'h00, "fw_zero");
    full_write(14'h0002, 32'h0000_0001, 6'h03, "fw_bit0");
    full_write(14'h0003, 32'hFFFF_FFFF, 6'h18, "fw_ones");
    full_write(14'h0004, 32'h8000_0000, 6'h26, "fw_bit31");
    step();
    check("idle_hold_wpar",  mem_wpar,  6'h26);
    check("idle_hold_wdata", mem_wdata, 32'h8000_0000);

    // Partial write: byte 0 replaced, rest from array
    wr_valid = 1'b1;
    wr_addr  = 14'd5;
    wr_data  = 32'h0000_00AA;
    wr_be    = 4'b0001;
    step();
    wr_valid = 1'b0;
    check("rmw_rden",     mem_rden, 1'b1);
    check("rmw_rd_addr",  mem_addr, 14'd5);
    check("rmw_rd_we",    mem_we,   1'b0);
    check("rmw_rd_ready", wr_ready, 1'b0);
    step();
    check("rmw_rden_once", mem_rden, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1122_3344;
    step();
    mem_rvalid = 1'b0;
    check("rmw_we",    mem_we,    1'b1);
    check("rmw_rden2", mem_rden,  1'b0);
    check("rmw_addr",  mem_addr,  14'd5);
    check("rmw_wdata", mem_wdata, 32'h1122_33AA);
    check("rmw_wpar",  mem_wpar,  calc_par(32'h1122_33AA));
    check("rmw_decode", decode(mem_wdata, mem_wpar), 32'h1122_33AA);
    step();
    check("rmw_done_we",    mem_we,   1'b0);
    check("rmw_done_ready", wr_ready, 1'b1);

    // Stalled read; a stray RVALID during RD_REQ must be ignored
    wr_valid = 1'b1;
    wr_addr  = 14'h3FFF;
    wr_data  = 32'hDEAD_BEEF;
    wr_be    = 4'b1100;
    step();
    wr_valid = 1'b0;
    check("stall_rden", mem_rden, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    check("stall_stray_we", mem_we, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("stall_ready_%0d", i), wr_ready, 1'b0);
      check($sformatf("stall_we_%0d", i),    mem_we,   1'b0);
      check($sformatf("stall_rden_%0d", i),  mem_rden, 1'b0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0102_0304;
    step();
    mem_rvalid = 1'b0;
    check("stall_we",    mem_we,    1'b1);
    check("stall_addr",  mem_addr,  14'h3FFF);
    check("stall_wdata", mem_wdata, 32'hDEAD_0304);
    check("stall_wpar",  mem_wpar,  calc_par(32'hDEAD_0304));
    step();
    check("stall_done_we", mem_we, 1'b0);

    // BE=0: accepted, no memory access
    wr_valid = 1'b1;
    wr_addr  = 14'h0055;
    wr_data  = 32'hCAFE_F00D;
    wr_be    = 4'h0;
    step();
    wr_valid = 1'b0;
    check("be0_we",    mem_we,    1'b0);
    check("be0_rden",  mem_rden,  1'b0);
    check("be0_ready", wr_ready,  1'b1);
    check("be0_wdata", mem_wdata, 32'hDEAD_0304);
    step();
    check("be0_we2",   mem_we,    1'b0);
    check("be0_rden2", mem_rden,  1'b0);

    // Reset during WRITE
    wr_valid = 1'b1;
    wr_addr  = 14'd9;
    wr_data  = 32'h1234_5678;
    wr_be    = 4'hF;
    step();
    wr_valid = 1'b0;
    check("rw_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rw_we",    mem_we,    1'b0);
    check("rw_ready", wr_ready,  1'b0);
    check("rw_addr",  mem_addr,  '0);
    check("rw_wdata", mem_wdata, '0);
    check("rw_wpar",  mem_wpar,  '0);
    step();
    check("rw_we_held", mem_we, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rw_release_ready", wr_ready, 1'b1);
    @(negedge clk);

    // Reset during RD_WAIT, then a late RVALID
    wr_valid = 1'b1;
    wr_addr  = 14'd7;
    wr_data  = 32'h0000_5500;
    wr_be    = 4'b0010;
    step();
    wr_valid = 1'b0;
    check("rr_rden", mem_rden, 1'b1);
    step();
    check("rr_wait_ready", wr_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rr_ready", wr_ready,  1'b0);
    check("rr_rden0", mem_rden,  1'b0);
    check("rr_we0",   mem_we,    1'b0);
    check("rr_addr",  mem_addr,  '0);
    check("rr_wdata", mem_wdata, '0);
    check("rr_wpar",  mem_wpar,  '0);
    step();
    rst_n = 1'b1;
    #1;
    check("rr_release_ready", wr_ready, 1'b1);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5_A5A5;
    step();
    mem_rvalid = 1'b0;
    check("rr_late_we",   mem_we,   1'b0);
    check("rr_late_rden", mem_rden, 1'b0);
    step();
    check("rr_late_we2",   mem_we,    1'b0);
    check("rr_late_wdata", mem_wdata, '0);

    // Loopback: encode, flip one stored bit, correct
    for (int it = 0; it < 1000; it++) begin
      d = $urandom;
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'($urandom);
      wr_data  = d;
      wr_be    = 4'hF;
      step();
      wr_valid = 1'b0;
      sd = mem_wdata;
      sp = mem_wpar;
      p  = calc_par(d);
      check($sformatf("lb_wpar_%0d", it), sp, p);
      idx = $urandom_range(37, 0);
      if (idx < 32) sd[idx] = ~sd[idx];
      else          sp[idx - 32] = ~sp[idx - 32];
      check($sformatf("lb_corr_%0d", it), decode(sd, sp), d);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/otter_mem_ecc_encoder.md
OTTER_MEM_ECC_ENCODER -- requirements
Module: otter_mem_ecc_encoder

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width.
REQ-002 MEM_CLK  in  1  sole clock, all state on rising edge.
REQ-003 MEM_RST_N  in  1  asynchronous, active-low reset.
REQ-004 WR_VALID  in  1  write request valid.
REQ-005 WR_READY  out  1  request accepted when WR_VALID and WR_READY are both high at a rising edge.
REQ-006 WR_ADDR  in  ADDR_W  word address.
REQ-007 WR_DATA  in  32  write data.
REQ-008 WR_BE  in  4  byte enables; bit j selects byte j = data[8j+7:8j].
REQ-009 MEM_RDEN  out  1  one-cycle read strobe to the protected array.
REQ-010 MEM_RVALID  in  1  corrected read word is present on MEM_RDATA.
REQ-011 MEM_RDATA  in  32  corrected read word from the checker path.
REQ-012 MEM_WE  out  1  one-cycle write strobe.
REQ-013 MEM_ADDR  out  ADDR_W  address for read or write.
REQ-014 MEM_WDATA  out  32  data word to store.
REQ-015 MEM_WPAR  out  6  Hamming check bits to store alongside MEM_WDATA.

Function
REQ-016 Codeword layout: positions 1..38; check bits at 1,2,4,8,16,32; data bits 0..31 fill the remaining positions in ascending order (data0 at 3, data31 at 38).
REQ-017 MEM_WPAR[k] = XOR of all data bits whose position has bit k set, k=0..5.
REQ-018 MEM_WPAR shall match bit-for-bit the check bits the read-side checker recomputes; PAR[0] corresponds to position 1.
REQ-019 FSM states: IDLE, RD_REQ, RD_WAIT, WRITE.
REQ-020 WR_READY shall be high only in IDLE.
REQ-021 On acceptance, WR_ADDR, WR_DATA and WR_BE shall be captured into internal registers.
REQ-022 On acceptance with BE=4'hF: next state WRITE, and the parity register is loaded from WR_DATA in the same edge.
REQ-023 On acceptance with BE=4'h0: no memory access; remain IDLE.
REQ-024 On acceptance with any other BE: next state RD_REQ (read-modify-write).
REQ-025 RD_REQ: MEM_RDEN=1 and MEM_ADDR=captured address for exactly one cycle; next state RD_WAIT.
REQ-026 RD_WAIT: hold until MEM_RVALID=1.
REQ-027 RD_WAIT exit: on the MEM_RVALID edge, merge byte j from captured WR_DATA if BE[j]=1, else from MEM_RDATA.
REQ-028 The merged word and its parity shall be registered on that edge; next state WRITE.
REQ-029 MEM_RVALID outside RD_WAIT shall be ignored.
REQ-030 WRITE: MEM_WE=1 for exactly one cycle, with MEM_ADDR, MEM_WDATA and MEM_WPAR from registers; next state IDLE.
REQ-031 Latency, full write: accepted at edge N -> MEM_WE high in cycle N+1 -> WR_READY high again in cycle N+2.
REQ-032 Latency, partial write: MEM_RDEN in cycle N+1; MEM_WE in the cycle after MEM_RVALID.
REQ-033 MEM_WE and MEM_RDEN shall never be high in the same cycle.
REQ-034 In IDLE, MEM_ADDR/MEM_WDATA/MEM_WPAR hold their last values; MEM_WE=MEM_RDEN=0.

Reset
REQ-035 Assertion of MEM_RST_N low shall immediately force IDLE, regardless of the current state, including RD_WAIT and WRITE.
REQ-036 During reset: MEM_WE=0, MEM_RDEN=0, WR_READY=0.
REQ-037 During reset: MEM_ADDR, MEM_WDATA and MEM_WPAR all zero; captured registers all zero.
REQ-038 A reset during RD_WAIT or WRITE abandons the operation with no MEM_WE pulse.
REQ-039 WR_READY shall rise in the first cycle after MEM_RST_N deasserts.

Structure
REQ-040 Shared package otter_ecc_pkg shall hold the FSM state enum, the 6-bit check-bit width constant, and the data-to-position map.
REQ-041 Parity generation shall be one combinational sub-module, otter_ecc_par_gen (32 in, 6 out), instantiated once and fed by a mux of WR_DATA and the merged word.

Verification
REQ-042 Full write, BE=F: data 0x00000000 -> MEM_WPAR=0x00; 0x00000001 -> 0x03; 0xFFFFFFFF -> 0x18; 0x80000000 -> 0x26; MEM_WE in cycle N+1.
REQ-043 Partial write: array holds 0x11223344; write BE=4'b0001, data 0x000000AA, addr 5 -> one MEM_RDEN at addr 5, then MEM_WE with MEM_WDATA=0x112233AA and matching parity.
REQ-044 RD_WAIT stall: MEM_RVALID delayed 7 cycles -> WR_READY stays low throughout and MEM_WE follows MEM_RVALID by one cycle.
REQ-045 BE=0 request -> no MEM_RDEN/MEM_WE; WR_READY high next cycle.
REQ-046 Reset asserted in RD_WAIT -> outputs zero immediately; a late MEM_RVALID produces no MEM_WE.
REQ-047 Loopback: encode a random word, flip any single stored bit, feed it through the read-side checker -> original word recovered (1000 iterations).
